// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result {remainder, quotient} to HILO.
// Optional DIV_EARLY_TERM_EN: finish in FREE when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DVD_W = 2 * WIDTH + 1;

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVD_W-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               signed_q, signed_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

  assign result_o = result_q;
  assign ready_o  = ready_q;

  // Operand magnitudes, trial subtraction and final sign correction
  always_comb begin
    mag_a    = (signed_div_i && opdata1_i[WIDTH-1]) ? WIDTH'(0) - opdata1_i : opdata1_i;
    mag_b    = (signed_div_i && opdata2_i[WIDTH-1]) ? WIDTH'(0) - opdata2_i : opdata2_i;
    trial    = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
    quot_raw = dividend_q[WIDTH-1:0];
    rem_raw  = dividend_q[2*WIDTH:WIDTH+1];
    quot_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? WIDTH'(0) - quot_raw : quot_raw;
    rem_fix  = (signed_q && sign_a_q) ? WIDTH'(0) - rem_raw : rem_raw;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          signed_d = signed_div_i;
          sign_a_d = opdata1_i[WIDTH-1];
          sign_b_d = opdata2_i[WIDTH-1];
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (mag_a < mag_b) begin
            state_d  = DIV_END;
            result_d = {opdata1_i, WIDTH'(0)};
            ready_d  = DIV_RESULT_READY;
          end
`endif
          else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {WIDTH'(0), mag_a, 1'b0};
            divisor_d  = mag_b;
          end
        end
      end

      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          // Borrow means the divisor did not fit: shift in a 0 quotient bit
          if (trial[WIDTH]) begin
            dividend_d = {dividend_q[DVD_W-2:0], 1'b0};
          end else begin
            dividend_d = {trial[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected results, monitor checks on ready_o.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t sb_q[$];

`ifdef DIV_EARLY_TERM_EN
  localparam int SMALL_LAT = 0;
`else
  localparam int SMALL_LAT = 33;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every rising ready_o must match the oldest queued expectation
  logic ready_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready && !ready_seen) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.at));
      end
    end
    ready_seen = ready;
  end

  // Called at a negedge; issues the op, waits for ready, holds start, then drops it
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    int n;
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    sb_q.push_back('{exp, cyc + 1 + lat});
    @(negedge clk);
    op1 = ~a;
    op2 = b ^ 32'h5;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    check("held_ready", 64'(ready), 64'd1);
    check("held_result", result, exp);
    start = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready), 64'd0);
    check("drop_result", result, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    start = 1'b0;
    annul = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33);
    run_op(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
    run_op(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_op(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
    run_op(1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 1);
    run_op(1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 33);
    run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_op(1'b0, 32'd3,          32'd5,        64'h00000003_00000000, SMALL_LAT);

    // Annul at cnt=10, then restart immediately with 9/3
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    annul = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Reset mid-operation at cnt=20: no ready may ever appear for it
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_idle", 64'(ready), 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
